// File: rtl/mem_wb_pkg.sv
// Shared definitions for the MEM->WB stage register: control-word bit positions,
// the packed entry layout at default widths, and an entry-width helper.
package mem_wb_pkg;

  localparam int unsigned REGWRITE  = 0;
  localparam int unsigned MEMTOREG  = 1;
  localparam int unsigned JMPLINK   = 2;
  localparam int unsigned FPWRITE   = 3;
  localparam int unsigned LOHIWRITE = 4;
  localparam int unsigned COMPARE   = 5;
  localparam int unsigned MEMWRITE  = 6;
  localparam int unsigned RMEMTOREG = 7;

  localparam int unsigned DefDataW = 64;
  localparam int unsigned DefRegAw = 5;
  localparam int unsigned DefCtrlW = 8;

  typedef struct packed {
    logic [DefDataW-1:0] mem_data;
    logic [DefDataW-1:0] alu_data;
    logic [DefRegAw-1:0] dst_reg;
    logic [DefRegAw-1:0] fp_dst_reg;
    logic [DefCtrlW-1:0] ctrl;
  } mem_wb_entry_t;

  // Flat width of {mem_data, alu_data, dst_reg, fp_dst_reg, ctrl} for any parameterisation.
  function automatic int unsigned entry_width(int unsigned data_w, int unsigned reg_aw,
                                              int unsigned ctrl_w);
    return 2 * data_w + 2 * reg_aw + ctrl_w;
  endfunction

endpackage

// File: rtl/mem_wb_entry_reg.sv
// One valid bit plus payload. Clear drops the valid bit but keeps the payload;
// clear wins over load.
module mem_wb_entry_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] d_i,
  output logic         valid_o,
  output logic [W-1:0] q_o
);

  logic         valid_d, valid_q;
  logic [W-1:0] data_d, data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clr_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = d_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign q_o     = data_q;

endmodule

// File: rtl/mem_wb_stage_reg.sv
// MEM->WB pipeline register with valid/ready handshake, optional 2-entry skid buffer,
// synchronous flush, writeback forwarding tap and a saturating stall counter.
module mem_wb_stage_reg
  import mem_wb_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_mem_data,
  input  logic [DATA_W-1:0] in_alu_data,
  input  logic [REG_AW-1:0] in_dst_reg,
  input  logic [REG_AW-1:0] in_fp_dst_reg,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_mem_data,
  output logic [DATA_W-1:0] out_alu_data,
  output logic [REG_AW-1:0] out_dst_reg,
  output logic [REG_AW-1:0] out_fp_dst_reg,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_reg,
  output logic              fwd_is_fp,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int unsigned EW = entry_width(DATA_W, REG_AW, CTRL_W);

  logic [EW-1:0] in_entry, main_d, main_q;
  logic          main_valid, main_load, main_clr;
  logic          accept, retire;

  assign in_entry = {in_mem_data, in_alu_data, in_dst_reg, in_fp_dst_reg, in_ctrl};
  assign accept   = in_valid && in_ready;
  assign retire   = main_valid && out_ready;

  mem_wb_entry_reg #(.W(EW)) u_main (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .clr_i  (main_clr),
    .load_i (main_load),
    .d_i    (main_d),
    .valid_o(main_valid),
    .q_o    (main_q)
  );

  if (SKID != 0) begin : g_skid
    logic          skid_valid, skid_load, skid_clr;
    logic [EW-1:0] skid_q;

    // skid_valid is a flop, so in_ready has no combinational path from out_ready.
    assign in_ready = !skid_valid;

    always_comb begin
      main_load = 1'b0;
      main_clr  = flush;
      main_d    = in_entry;
      skid_load = 1'b0;
      skid_clr  = flush;
      if (!flush) begin
        if (retire) begin
          if (skid_valid) begin
            main_load = 1'b1;
            main_d    = skid_q;
            skid_clr  = 1'b1;
          end else if (accept) begin
            main_load = 1'b1;
          end else begin
            main_clr = 1'b1;
          end
        end else if (accept) begin
          if (main_valid) skid_load = 1'b1;
          else            main_load = 1'b1;
        end
      end
    end

    mem_wb_entry_reg #(.W(EW)) u_skid (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .clr_i  (skid_clr),
      .load_i (skid_load),
      .d_i    (in_entry),
      .valid_o(skid_valid),
      .q_o    (skid_q)
    );
  end else begin : g_flat
    assign in_ready = !main_valid || out_ready;

    always_comb begin
      main_d    = in_entry;
      main_clr  = flush || (retire && !accept);
      main_load = !flush && accept;
    end
  end

  assign out_valid = main_valid;
  assign {out_mem_data, out_alu_data, out_dst_reg, out_fp_dst_reg, out_ctrl} = main_q;

  assign fwd_is_fp = out_ctrl[FPWRITE];
  assign fwd_valid = main_valid && (out_ctrl[REGWRITE] || out_ctrl[FPWRITE]);
  assign fwd_reg   = fwd_is_fp ? out_fp_dst_reg : out_dst_reg;
  assign fwd_data  = out_ctrl[MEMTOREG] ? out_mem_data : out_alu_data;

  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (main_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_mem_wb_stage_reg.sv
// Drives a skid (SKID=1, CNT_W=4) and a flat (SKID=0) instance with the same stimulus
// and compares both against a FIFO-of-capacity model.
module tb_mem_wb_stage_reg;
  import mem_wb_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  mem_wb_entry_t in_e = '0;

  logic        ir[2], ov[2], fv[2], ffp[2];
  logic [63:0] omem[2], oalu[2], fdat[2];
  logic [4:0]  odst[2], ofp[2], freg[2];
  logic [7:0]  octl[2];
  logic [3:0]  sc0;
  logic [15:0] sc1;

  always #5 clk = ~clk;

  mem_wb_stage_reg #(.SKID(1), .CNT_W(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
    .in_mem_data(in_e.mem_data), .in_alu_data(in_e.alu_data), .in_dst_reg(in_e.dst_reg),
    .in_fp_dst_reg(in_e.fp_dst_reg), .in_ctrl(in_e.ctrl), .out_valid(ov[0]),
    .out_ready(out_ready), .out_mem_data(omem[0]), .out_alu_data(oalu[0]),
    .out_dst_reg(odst[0]), .out_fp_dst_reg(ofp[0]), .out_ctrl(octl[0]),
    .fwd_valid(fv[0]), .fwd_reg(freg[0]), .fwd_is_fp(ffp[0]), .fwd_data(fdat[0]),
    .stall_cnt(sc0)
  );

  mem_wb_stage_reg #(.SKID(0), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
    .in_mem_data(in_e.mem_data), .in_alu_data(in_e.alu_data), .in_dst_reg(in_e.dst_reg),
    .in_fp_dst_reg(in_e.fp_dst_reg), .in_ctrl(in_e.ctrl), .out_valid(ov[1]),
    .out_ready(out_ready), .out_mem_data(omem[1]), .out_alu_data(oalu[1]),
    .out_dst_reg(odst[1]), .out_fp_dst_reg(ofp[1]), .out_ctrl(octl[1]),
    .fwd_valid(fv[1]), .fwd_reg(freg[1]), .fwd_is_fp(ffp[1]), .fwd_data(fdat[1]),
    .stall_cnt(sc1)
  );

  int n_checks = 0;
  int n_fail = 0;

  // Model: per instance a FIFO of capacity 2 (skid) or 1 (flat) and a stall count.
  mem_wb_entry_t m_ent[2][2];
  int m_n[2];
  int m_stall[2];
  int m_max[2] = '{15, 65535};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic model_ready(input int i, input logic ordy);
    if (i == 0) return m_n[0] < 2;
    return (m_n[1] == 0) || ordy;
  endfunction

  function automatic mem_wb_entry_t mk(input logic [63:0] md, input logic [63:0] ad,
                                       input logic [4:0] dr, input logic [4:0] fr,
                                       input logic [7:0] c);
    mem_wb_entry_t e;
    e.mem_data = md; e.alu_data = ad; e.dst_reg = dr; e.fp_dst_reg = fr; e.ctrl = c;
    return e;
  endfunction

  function automatic mem_wb_entry_t rand_entry();
    logic [31:0] r;
    r = $urandom;
    return mk({$urandom, $urandom}, {$urandom, $urandom}, r[4:0], r[9:5], r[17:10]);
  endfunction

  task automatic reset_model();
    for (int i = 0; i < 2; i++) begin
      m_n[i] = 0;
      m_stall[i] = 0;
    end
  endtask

  task automatic check_outputs();
    for (int i = 0; i < 2; i++) begin
      mem_wb_entry_t e;
      logic [63:0] sc;
      logic exp_fp;
      sc = (i == 0) ? {60'd0, sc0} : {48'd0, sc1};
      check_eq($sformatf("u%0d.in_ready", i), ir[i], model_ready(i, out_ready));
      check_eq($sformatf("u%0d.out_valid", i), ov[i], m_n[i] > 0);
      check_eq($sformatf("u%0d.stall_cnt", i), sc, m_stall[i]);
      if (m_n[i] > 0) begin
        e = m_ent[i][0];
        exp_fp = e.ctrl[FPWRITE];
        check_eq($sformatf("u%0d.out_mem_data", i), omem[i], e.mem_data);
        check_eq($sformatf("u%0d.out_alu_data", i), oalu[i], e.alu_data);
        check_eq($sformatf("u%0d.out_dst_reg", i), odst[i], e.dst_reg);
        check_eq($sformatf("u%0d.out_fp_dst_reg", i), ofp[i], e.fp_dst_reg);
        check_eq($sformatf("u%0d.out_ctrl", i), octl[i], e.ctrl);
        check_eq($sformatf("u%0d.fwd_valid", i), fv[i], e.ctrl[REGWRITE] || exp_fp);
        check_eq($sformatf("u%0d.fwd_is_fp", i), ffp[i], exp_fp);
        check_eq($sformatf("u%0d.fwd_reg", i), freg[i], exp_fp ? e.fp_dst_reg : e.dst_reg);
        check_eq($sformatf("u%0d.fwd_data", i), fdat[i],
                 e.ctrl[MEMTOREG] ? e.mem_data : e.alu_data);
      end else begin
        check_eq($sformatf("u%0d.fwd_valid", i), fv[i], 1'b0);
      end
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input logic iv, input logic ordy, input logic fl, input mem_wb_entry_t e);
    logic acc[2], ret[2];
    in_valid = iv; out_ready = ordy; flush = fl; in_e = e;
    #1;
    check_outputs();
    for (int i = 0; i < 2; i++) begin
      acc[i] = iv && model_ready(i, ordy);
      ret[i] = (m_n[i] > 0) && ordy;
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (m_n[i] > 0 && !ordy && m_stall[i] < m_max[i]) m_stall[i]++;
      if (fl) begin
        m_n[i] = 0;
      end else begin
        if (ret[i]) begin
          m_ent[i][0] = m_ent[i][1];
          m_n[i]--;
        end
        if (acc[i]) begin
          m_ent[i][m_n[i]] = e;
          m_n[i]++;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    reset_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  mem_wb_entry_t ea, eb, ec;
  logic [31:0] r;

  initial begin
    do_reset();
    check_eq("rst.out_valid0", ov[0], 1'b0);
    check_eq("rst.out_valid1", ov[1], 1'b0);
    check_eq("rst.in_ready0", ir[0], 1'b1);
    check_eq("rst.in_ready1", ir[1], 1'b1);
    check_eq("rst.out_mem_data0", omem[0], 64'd0);
    check_eq("rst.out_ctrl1", octl[1], 8'd0);
    check_eq("rst.stall0", sc0, 4'd0);

    // Single entry with a load forward.
    step(1'b1, 1'b1, 1'b0, mk(64'hDEAD, 64'h0, 5'd7, 5'd0, 8'h03));
    check_eq("single.out_valid", ov[0], 1'b1);
    check_eq("single.fwd_valid", fv[0], 1'b1);
    check_eq("single.fwd_reg", freg[0], 5'd7);
    check_eq("single.fwd_data", fdat[0], 64'hDEAD);
    step(1'b0, 1'b1, 1'b0, '0);
    check_eq("single.drained", ov[0], 1'b0);

    // Back-pressure fills the skid entry.
    ea = rand_entry(); eb = rand_entry();
    step(1'b1, 1'b0, 1'b0, ea);
    step(1'b1, 1'b0, 1'b0, eb);
    check_eq("bp.in_ready_low", ir[0], 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, '0);
    check_eq("bp.second_out", omem[0], eb.mem_data);
    step(1'b0, 1'b1, 1'b0, '0);
    check_eq("bp.empty", ov[0], 1'b0);
    check_eq("bp.in_ready_back", ir[0], 1'b1);

    // Back-to-back stream.
    repeat (8) step(1'b1, 1'b1, 1'b0, rand_entry());
    repeat (2) step(1'b0, 1'b1, 1'b0, '0);

    // Flush with a simultaneous accept.
    ea = rand_entry(); ec = rand_entry();
    step(1'b1, 1'b0, 1'b0, ea);
    step(1'b1, 1'b0, 1'b1, ec);
    check_eq("flush.out_valid0", ov[0], 1'b0);
    check_eq("flush.in_ready0", ir[0], 1'b1);
    check_eq("flush.out_valid1", ov[1], 1'b0);
    repeat (3) step(1'b0, 1'b1, 1'b0, '0);

    // FP forward of an ALU value.
    step(1'b1, 1'b1, 1'b0, mk(64'h0, 64'h3FF0000000000000, 5'd0, 5'd12, 8'h09));
    check_eq("fp.fwd_is_fp", ffp[0], 1'b1);
    check_eq("fp.fwd_reg", freg[0], 5'd12);
    check_eq("fp.fwd_data", fdat[0], 64'h3FF0000000000000);
    step(1'b0, 1'b1, 1'b0, '0);

    // Stall counter saturation, then asynchronous reset mid-stall.
    do_reset();
    step(1'b1, 1'b0, 1'b0, rand_entry());
    repeat (20) step(1'b0, 1'b0, 1'b0, '0);
    check_eq("sat.stall0", sc0, 4'd15);
    check_eq("sat.stall1", sc1, 16'd20);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst.out_valid0", ov[0], 1'b0);
    check_eq("arst.stall0", sc0, 4'd0);
    check_eq("arst.out_valid1", ov[1], 1'b0);
    check_eq("arst.stall1", sc1, 16'd0);
    check_eq("arst.out_mem_data0", omem[0], 64'd0);
    reset_model();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomised traffic.
    repeat (1500) begin
      r = $urandom;
      step(r[3:0] < 4'd11, r[7:4] < 4'd10, r[13:8] < 6'd3, rand_entry());
    end
    step(1'b0, 1'b1, 1'b0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
